wb_flash_rdc: RTL

WB_FLASH_RDC -- requirements
Module: wb_flash_rdc

---
 rtl/wb_flash_rdc.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/wb_flash_rdc.sv
// Wishbone read-only bridge to a narrow parallel flash with a one-word read buffer.
// Each 32-bit word is assembled big-endian from N = 32/FLASH_DW flash beats.
module wb_flash_rdc #(
    parameter int FLASH_DW = 8,
    parameter int FLASH_AW = 22,
    parameter int WAIT_CYC = 3
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [31:0]         wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    input  logic [3:0]          wb_sel_i,
    output logic [31:0]         wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    input  logic                inval_i,
    output logic [FLASH_AW-1:0] flash_adr_o,
    input  logic [FLASH_DW-1:0] flash_dat_i,
    output logic                flash_rst,
    output logic                flash_ce,
    output logic                flash_oe,
    output logic                flash_we
);

    localparam int         N         = 32 / FLASH_DW;
    localparam int         LOG2N     = (N == 4) ? 2 : 1;
    localparam logic [3:0] CNT_LAST  = 4'(WAIT_CYC - 1);
    localparam logic [1:0] BEAT_LAST = 2'(N - 1);

    typedef enum logic [1:0] {IDLE, READ, ACK, ERR} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [29:0] r_word;
    logic [1:0]  r_beat;
    logic [3:0]  r_cnt;
    logic        r_valid;
    logic [29:0] r_buf_word;
    logic [31:0] r_buf_data;
    logic [31:0] r_fill;

    logic        w_access;
    logic        w_hit;
    logic        w_start;
    logic        w_sample;
    logic        w_last;
    logic [31:0] w_fill_next;
    logic [31:0] w_start_lin;
    logic        w_unused;

    assign w_unused = ^{wb_dat_i, wb_sel_i, wb_adr_i[1:0]};

    always_comb begin
        w_access    = wb_cyc_i & wb_stb_i;
        w_hit       = r_valid && (wb_adr_i[31:2] == r_buf_word);
        w_start     = (r_state == IDLE) && w_access && !wb_we_i && !w_hit;
        w_sample    = (r_state == READ) && w_access && (r_cnt == CNT_LAST);
        w_last      = w_sample && (r_beat == BEAT_LAST);
        w_start_lin = {2'b00, wb_adr_i[31:2]} << LOG2N;
        // Beat 0 lands in the most significant lane.
        w_fill_next = r_fill;
        w_fill_next[(N - 1 - int'(r_beat)) * FLASH_DW +: FLASH_DW] = flash_dat_i;

        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (wb_we_i)    w_next = ERR;
                    else if (w_hit) w_next = ACK;
                    else            w_next = READ;
                end
            end
            READ: begin
                if (!w_access)   w_next = IDLE;
                else if (w_last) w_next = ACK;
            end
            ACK:     w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase

        wb_ack_o  = (r_state == ACK);
        wb_err_o  = (r_state == ERR);
        flash_ce  = (r_state != READ);
        flash_oe  = (r_state != READ);
        flash_we  = 1'b1;
        flash_rst = !wb_rst_i;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_beat      <= 2'd0;
            r_cnt       <= 4'd0;
            r_valid     <= 1'b0;
            flash_adr_o <= '0;
            wb_dat_o    <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_access && !wb_we_i && w_hit)
                wb_dat_o <= r_buf_data;
            if (w_start) begin
                r_beat      <= 2'd0;
                r_cnt       <= 4'd0;
                flash_adr_o <= w_start_lin[FLASH_AW-1:0];
            end
            if (r_state == READ && w_access) begin
                if (w_sample) begin
                    r_cnt       <= 4'd0;
                    r_beat      <= r_beat + 2'd1;
                    flash_adr_o <= flash_adr_o + FLASH_AW'(1);
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
            if (w_last)
                wb_dat_o <= w_fill_next;
            // Invalidate wins over a fill completing on the same edge.
            if (inval_i)
                r_valid <= 1'b0;
            else if (w_last)
                r_valid <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_start)
            r_word <= wb_adr_i[31:2];
        if (w_sample)
            r_fill <= w_fill_next;
        if (w_last) begin
            r_buf_data <= w_fill_next;
            r_buf_word <= r_word;
        end
    end

endmodule
